// File: rtl/da_pkg.sv
// Shared types and helpers for the distributed-arithmetic accumulator.
// Holds the internal-width rule and the signed range test used for clipping.
package da_pkg;

  localparam int DA_NBITS_DEF = 16;

  // Counter type for the default sample width; the top derives its own from NBITS.
  typedef logic [$clog2(DA_NBITS_DEF)-1:0] da_cnt_t;

  typedef enum logic [1:0] {
    DA_FIT     = 2'b00,
    DA_OVF_POS = 2'b01,
    DA_OVF_NEG = 2'b10
  } da_sat_e;

  function automatic int da_int_width(input int lut_w, input int num_lut, input int nbits);
    return lut_w + $clog2(num_lut) + nbits;
  endfunction

  // Classifies v against the signed w-bit range.
  function automatic da_sat_e da_sat_code(input longint v, input int w);
    longint hi;
    longint lo;
    if (w >= 64) return DA_FIT;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return DA_OVF_POS;
    if (v < lo) return DA_OVF_NEG;
    return DA_FIT;
  endfunction

endpackage

// File: rtl/da_adder_tree.sv
// Combinational binary adder tree over NUM_LUT signed LUT words.
// Each level grows by one bit; the root is sign-extended to OUT_W.
module da_adder_tree #(
  parameter int NUM_LUT = 8,
  parameter int LUT_W   = 16,
  parameter int OUT_W   = 35
) (
  input  logic [NUM_LUT*LUT_W-1:0] lut_in,
  output logic signed [OUT_W-1:0]  sum
);

  localparam int LEVELS = $clog2(NUM_LUT);

  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int N = NUM_LUT >> l;
    logic signed [LUT_W+l-1:0] v [N];

    if (l == 0) begin : g_in
      for (genvar k = 0; k < N; k++) begin : g_word
        assign v[k] = $signed(lut_in[k*LUT_W +: LUT_W]);
      end
    end else begin : g_add
      for (genvar k = 0; k < N; k++) begin : g_pair
        assign v[k] = (LUT_W+l)'(g_lvl[l-1].v[2*k]) + (LUT_W+l)'(g_lvl[l-1].v[2*k+1]);
      end
    end
  end

  assign sum = OUT_W'(g_lvl[LEVELS].v[0]);

endmodule

// File: rtl/da_accum.sv
// MSB-first DA shift-accumulate engine with a one-entry ready/valid result buffer.
// Define DA_SAT_EN to clip results to the signed ACC_W range; otherwise they wrap.
module da_accum #(
  parameter int NUM_LUT = 8,
  parameter int LUT_W   = 16,
  parameter int NBITS   = 16,
  parameter int ACC_W   = 32
) (
  input  logic                     clk3,
  input  logic                     reset,
  input  logic                     clear,
  input  logic [NUM_LUT*LUT_W-1:0] lut_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [ACC_W-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sat,
  output logic                     busy
);

  import da_pkg::*;

  localparam int W_INT = da_int_width(LUT_W, NUM_LUT, NBITS);
  localparam int CNT_W = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBITS - 1);

  logic [CNT_W-1:0]        cnt_p0;
  logic signed [W_INT-1:0] acc_p0;
  logic signed [W_INT-1:0] tree_sum;
  logic signed [W_INT-1:0] acc_nxt;
  logic                    is_last;
  logic                    take;
  logic [ACC_W-1:0]        res_data;
  logic                    res_sat;

`ifdef DA_SAT_EN
  function automatic logic [ACC_W-1:0] sat_data(input logic signed [W_INT-1:0] v);
    case (da_sat_code(longint'(v), ACC_W))
      DA_OVF_POS: return {1'b0, {(ACC_W-1){1'b1}}};
      DA_OVF_NEG: return {1'b1, {(ACC_W-1){1'b0}}};
      default:    return ACC_W'(v);
    endcase
  endfunction

  function automatic logic sat_flag(input logic signed [W_INT-1:0] v);
    return da_sat_code(longint'(v), ACC_W) != DA_FIT;
  endfunction
`endif

  da_adder_tree #(
    .NUM_LUT (NUM_LUT),
    .LUT_W   (LUT_W),
    .OUT_W   (W_INT)
  ) u_tree (
    .lut_in (lut_in),
    .sum    (tree_sum)
  );

  assign is_last  = (cnt_p0 == CNT_LAST);
  // Only the final slice can stall, and only when the buffer cannot drain.
  assign in_ready = !(is_last && out_valid && !out_ready);
  assign take     = in_valid && in_ready && !clear;
  assign busy     = (cnt_p0 != '0);

  // The MSB slice carries negative weight in two's complement.
  always_comb begin
    acc_nxt = (cnt_p0 == '0) ? -tree_sum : (acc_p0 <<< 1) + tree_sum;
  end

  always_comb begin
`ifdef DA_SAT_EN
    res_data = sat_data(acc_nxt);
    res_sat  = sat_flag(acc_nxt);
`else
    res_data = ACC_W'(acc_nxt);
    res_sat  = 1'b0;
`endif
  end

  // ---- stage p0: slice counter and accumulator ----
  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      cnt_p0 <= '0;
      acc_p0 <= '0;
    end else if (clear) begin
      cnt_p0 <= '0;
      acc_p0 <= '0;
    end else if (take) begin
      acc_p0 <= acc_nxt;
      cnt_p0 <= is_last ? '0 : cnt_p0 + 1'b1;
    end
  end

  // ---- output buffer: loads on the final slice, drains on out_ready ----
  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (take && is_last) begin
      out_valid <= 1'b1;
      out_data  <= res_data;
      out_sat   <= res_sat;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_da_accum.sv
// Bench for da_accum: a 32-bit and a 16-bit result instance share one stimulus stream,
// checked each cycle against a weighted-sum sample model.
module tb_da_accum;

  localparam int NUM_LUT = 8;
  localparam int LUT_W   = 16;
  localparam int NBITS   = 4;
  localparam int LW      = NUM_LUT * LUT_W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          in_valid;
  logic          out_ready;
  logic [LW-1:0] lut_in;
  logic          rdy32, rdy16, ov32, ov16, sat32, sat16, busy32, busy16;
  logic [31:0]   d32;
  logic [15:0]   d16;

  int checks = 0;
  int errors = 0;
  bit rnd_rdy = 0;

  always #5 clk = ~clk;

  da_accum #(.NUM_LUT(NUM_LUT), .LUT_W(LUT_W), .NBITS(NBITS), .ACC_W(32)) u_dut32 (
    .clk3(clk), .reset(rst_n), .clear(clear), .lut_in(lut_in), .in_valid(in_valid),
    .in_ready(rdy32), .out_data(d32), .out_valid(ov32), .out_ready(out_ready),
    .out_sat(sat32), .busy(busy32)
  );

  da_accum #(.NUM_LUT(NUM_LUT), .LUT_W(LUT_W), .NBITS(NBITS), .ACC_W(16)) u_dut16 (
    .clk3(clk), .reset(rst_n), .clear(clear), .lut_in(lut_in), .in_valid(in_valid),
    .in_ready(rdy16), .out_data(d16), .out_valid(ov16), .out_ready(out_ready),
    .out_sat(sat16), .busy(busy16)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint slice_sum(input logic [LW-1:0] w);
    longint s = 0;
    for (int k = 0; k < NUM_LUT; k++) s += longint'($signed(w[k*LUT_W +: LUT_W]));
    return s;
  endfunction

  function automatic logic [LW-1:0] fill(input logic [LUT_W-1:0] v);
    logic [LW-1:0] w;
    for (int k = 0; k < NUM_LUT; k++) w[k*LUT_W +: LUT_W] = v;
    return w;
  endfunction

  function automatic logic [LW-1:0] rnd_words();
    logic [LW-1:0] w;
    int mode = $urandom_range(0, 3);
    for (int k = 0; k < NUM_LUT; k++) begin
      case (mode)
        0:       w[k*LUT_W +: LUT_W] = LUT_W'($urandom);
        1:       w[k*LUT_W +: LUT_W] = LUT_W'($urandom_range(0, 15)) - 16'd8;
        2:       w[k*LUT_W +: LUT_W] = ($urandom_range(0, 3) != 0) ? 16'h7FFF : 16'h0000;
        default: w[k*LUT_W +: LUT_W] = ($urandom_range(0, 3) != 0) ? 16'h8000 : 16'h0000;
      endcase
    end
    return w;
  endfunction

  // Reference model: slice sums of the current sample; value = -S0*2^(N-1) + sum Si*2^(N-1-i).
  longint      sums[$];
  bit          m_valid = 0;
  logic [31:0] m_d32 = '0;
  logic [15:0] m_d16 = '0;
  bit          m_sat16 = 0;

  always @(negedge clk) begin : mon
    bit     exp_rdy;
    bit     loaded;
    longint r;
    if (!rst_n) begin
      sums.delete();
      m_valid = 0;
      m_d32   = '0;
      m_d16   = '0;
      m_sat16 = 0;
    end
    exp_rdy = !(sums.size() == NBITS - 1 && m_valid && !out_ready);
    chk("in_ready32", rdy32, exp_rdy);
    chk("in_ready16", rdy16, exp_rdy);
    chk("busy32", busy32, sums.size() != 0);
    chk("busy16", busy16, sums.size() != 0);
    chk("out_valid32", ov32, m_valid);
    chk("out_valid16", ov16, m_valid);
    chk("out_data32", d32, m_d32);
    chk("out_data16", d16, m_d16);
    chk("out_sat32", sat32, 0);
    chk("out_sat16", sat16, m_sat16);
    if (rst_n) begin
      loaded = 0;
      if (clear) begin
        sums.delete();
      end else if (in_valid && exp_rdy) begin
        sums.push_back(slice_sum(lut_in));
        if (sums.size() == NBITS) begin
          r = -sums[0] * (longint'(1) << (NBITS - 1));
          for (int i = 1; i < NBITS; i++) r += sums[i] * (longint'(1) << (NBITS - 1 - i));
          m_d32 = 32'(r);
`ifdef DA_SAT_EN
          if (r > 32767) begin
            m_d16 = 16'h7FFF; m_sat16 = 1;
          end else if (r < -32768) begin
            m_d16 = 16'h8000; m_sat16 = 1;
          end else begin
            m_d16 = 16'(r); m_sat16 = 0;
          end
`else
          m_d16   = 16'(r);
          m_sat16 = 0;
`endif
          m_valid = 1;
          loaded  = 1;
          sums.delete();
        end
      end
      if (!loaded && out_ready) m_valid = 0;
    end
  end

  task automatic send_slice(input logic [LW-1:0] w, input bit clr);
    bit done = 0;
    for (int t = 0; t < 64 && !done; t++) begin
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      lut_in   = w;
      clear    = clr;
      @(negedge clk);
      done = rdy32 || clr;
      @(posedge clk);
      #1;
    end
    clear = 1'b0;
    if (!done) chk("slice_timeout", done, 1);
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1; lut_in = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycle();

    // All words 1 on every slice: -8
    for (int s = 0; s < NBITS; s++) send_slice(fill(16'd1), 0);
    chk("ones_valid", ov32, 1);
    chk("ones_data", d32, 32'hFFFFFFF8);
    chk("ones_sat", sat32, 0);

    // LUT0=100 in the MSB slice, then in the LSB slice, back to back
    for (int s = 0; s < NBITS; s++) send_slice((s == 0) ? LW'(100) : '0, 0);
    chk("msb_data", d32, 32'hFFFFFCE0);
    for (int s = 0; s < NBITS; s++) send_slice((s == NBITS - 1) ? LW'(100) : '0, 0);
    chk("lsb_valid", ov32, 1);
    chk("lsb_data", d32, 32'd100);
    idle_cycle();

    // Back-pressure: first result held, second final slice stalls then drains
    out_ready = 1'b0;
    for (int s = 0; s < NBITS; s++) send_slice(rnd_words(), 0);
    for (int s = 0; s < NBITS - 1; s++) send_slice(rnd_words(), 0);
    in_valid = 1'b1;
    lut_in   = rnd_words();
    @(negedge clk);
    chk("stall_ready", rdy32, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("drain_ready", rdy32, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("second_valid", ov32, 1);
    idle_cycle();

    // Saturation: zero MSB slice, then three slices of 0x7FFF words
    send_slice('0, 0);
    for (int s = 1; s < NBITS; s++) send_slice(fill(16'h7FFF), 0);
    chk("sat_data32", d32, 32'd1834952);
`ifdef DA_SAT_EN
    chk("sat_data16", d16, 16'h7FFF);
    chk("sat_flag16", sat16, 1);
`else
    chk("sat_data16", d16, 16'hFFC8);
    chk("sat_flag16", sat16, 0);
`endif
    idle_cycle();

    // Asynchronous reset mid-sample
    send_slice(rnd_words(), 0);
    send_slice(rnd_words(), 0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("rst_busy", busy32, 0);
    chk("rst_valid", ov32, 0);
    chk("rst_data", d32, 0);
    chk("rst_ready", rdy32, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b0;
    for (int s = 0; s < NBITS; s++) send_slice(fill(16'd1), 0);
    chk("post_rst_data", d32, 32'hFFFFFFF8);

    // clear on slice 2 with a result still pending
    send_slice(rnd_words(), 0);
    send_slice(rnd_words(), 0);
    send_slice(rnd_words(), 1);
    chk("clr_busy", busy32, 0);
    chk("clr_hold_valid", ov32, 1);
    chk("clr_hold_data", d32, 32'hFFFFFFF8);
    out_ready = 1'b1;
    for (int s = 0; s < NBITS; s++) send_slice((s == 0) ? fill(16'd2) : '0, 0);
    chk("clr_result", d32, 32'hFFFFFF80);
    idle_cycle();

    // Randomized stream with random back-pressure, bubbles and clears
    rnd_rdy = 1;
    for (int n = 0; n < 60; n++) begin
      for (int s = 0; s < NBITS; s++) begin
        if ($urandom_range(0, 7) == 0) idle_cycle();
        send_slice(rnd_words(), $urandom_range(0, 23) == 0);
      end
    end
    rnd_rdy   = 0;
    out_ready = 1'b1;
    repeat (3) idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
